// File: rtl/rca_cfg_decoder.sv
// rca_cfg_decoder
//   Buffers RCA configuration instructions in an in-order FIFO and decodes
//   the head through an IDLE/DECODE/STALL/WRITE machine. Each legal
//   instruction produces one registered write strobe. A strobe is held off
//   while its target RCA is busy; global types wait until every RCA is idle.
//   Illegal instructions are dropped with a one-cycle illegal pulse.
// Ports
//   clk, rst_n        : clock, asynchronous active-low reset
//   issue_*           : valid/ready handshake with funct3/funct7/rs1/rs2
//   rca_busy          : per-RCA execute status
//   cfg_pending       : per-RCA "configuration still queued" flags
//   illegal           : one-cycle pulse when an illegal head is dropped
//   wr_rca/idx/val    : write target and payload (zero outside WRITE)
//   *_we, flag bits   : one-hot write enable and its qualifiers
// Optional feature
//   RCA_CFG_PERF_EN   : adds perf_writes / perf_stall_cycles counters
// FIFO_DEPTH must be a power of two, at least 2.
module rca_cfg_decoder #(
  parameter int unsigned NUM_RCAS   = 4,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                issue_valid,
  output logic                issue_ready,
  input  logic [2:0]          funct3,
  input  logic [6:0]          funct7,
  input  logic [31:0]         rs1_data,
  input  logic [31:0]         rs2_data,
  input  logic [NUM_RCAS-1:0] rca_busy,
  output logic [NUM_RCAS-1:0] cfg_pending,
  output logic                illegal,
  output logic [1:0]          wr_rca,
  output logic [5:0]          wr_idx,
  output logic [4:0]          wr_val,
  output logic                cpu_reg_we,
  output logic                cpu_reg_is_dest,
  output logic                cpu_reg_is_fb,
  output logic                grid_mux_we,
  output logic                io_mux_we,
  output logic                res_mux_we,
  output logic                res_mux_fb,
  output logic                io_use_we
`ifdef RCA_CFG_PERF_EN
  ,
  output logic [31:0]         perf_writes,
  output logic [31:0]         perf_stall_cycles
`endif
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  // Only the operand bits any write type can use are stored.
  typedef struct packed {
    logic [2:0] f3;
    logic [6:0] f7;
    logic [5:0] rs1;
    logic [4:0] rs2;
  } entry_t;

  typedef enum logic [1:0] {IDLE, DECODE, STALL, WRITE} state_t;

  state_t        state, state_n;
  entry_t        mem [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0]   count, count_n;
  logic          push, pop, load_wr, illegal_n;
  entry_t        head;
  logic          head_illegal, head_busy;

  logic unused_bits;
  assign unused_bits = ^{rs1_data[31:6], rs2_data[31:5]};

  assign push = issue_valid && issue_ready;
  assign head = mem[rd_ptr];
  assign count_n = count + (AW+1)'(push) - (AW+1)'(pop);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{f3: funct3, f7: funct7, rs1: rs1_data[5:0], rs2: rs2_data[4:0]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      issue_ready <= 1'b0;
      state       <= IDLE;
      illegal     <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count       <= count_n;
      // Registered from the next occupancy so a full FIFO is never overrun.
      issue_ready <= (count_n != (AW+1)'(FIFO_DEPTH));
      state       <= state_n;
      illegal     <= illegal_n;
    end
  end

  // Head classification: legality and whether its target is currently busy.
  always_comb begin
    logic per_rca, global_t;
    per_rca  = (head.f3 == 3'b001) || (head.f3 == 3'b100) || (head.f3 == 3'b101);
    global_t = (head.f3 == 3'b010) || (head.f3 == 3'b011);
    head_illegal = !(per_rca || global_t) || (per_rca && (head.f7 >= 7'(NUM_RCAS)));
    head_busy = 1'b0;
    if (global_t) begin
      head_busy = |rca_busy;
    end else begin
      for (int unsigned r = 0; r < NUM_RCAS; r++)
        if (head.f7 == 7'(r)) head_busy = rca_busy[r];
    end
  end

  always_comb begin
    state_n   = state;
    pop       = 1'b0;
    load_wr   = 1'b0;
    illegal_n = 1'b0;
    case (state)
      IDLE:   if (count != '0) state_n = DECODE;
      DECODE: begin
        if (head_illegal) begin
          pop       = 1'b1;
          illegal_n = 1'b1;
          state_n   = IDLE;
        end else if (head_busy) begin
          state_n = STALL;
        end else begin
          load_wr = 1'b1;
          state_n = WRITE;
        end
      end
      STALL: if (!head_busy) begin
        load_wr = 1'b1;
        state_n = WRITE;
      end
      WRITE: begin
        pop     = 1'b1;
        state_n = ((count > (AW+1)'(1)) || push) ? DECODE : IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Write outputs are loaded on the edge entering WRITE, so the strobe is
  // visible exactly during the WRITE cycle and cleared on the next edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_rca <= '0; wr_idx <= '0; wr_val <= '0;
      cpu_reg_we <= 1'b0; cpu_reg_is_dest <= 1'b0; cpu_reg_is_fb <= 1'b0;
      grid_mux_we <= 1'b0; io_mux_we <= 1'b0;
      res_mux_we <= 1'b0; res_mux_fb <= 1'b0; io_use_we <= 1'b0;
    end else begin
      wr_rca <= '0; wr_idx <= '0; wr_val <= '0;
      cpu_reg_we <= 1'b0; cpu_reg_is_dest <= 1'b0; cpu_reg_is_fb <= 1'b0;
      grid_mux_we <= 1'b0; io_mux_we <= 1'b0;
      res_mux_we <= 1'b0; res_mux_fb <= 1'b0; io_use_we <= 1'b0;
      if (load_wr) begin
        wr_rca <= head.f7[1:0];
        case (head.f3)
          3'b001: begin
            cpu_reg_we      <= 1'b1;
            wr_idx          <= {3'b000, head.rs1[2:0]};
            wr_val          <= head.rs2;
            cpu_reg_is_dest <= head.rs1[3];
            cpu_reg_is_fb   <= head.rs1[4];
          end
          3'b010: begin
            grid_mux_we <= 1'b1;
            wr_idx      <= head.rs1;
            wr_val      <= {2'b00, head.rs2[2:0]};
          end
          3'b011: begin
            io_mux_we <= 1'b1;
            wr_idx    <= head.rs1;
            wr_val    <= {2'b00, head.rs2[2:0]};
          end
          3'b100: begin
            res_mux_we <= 1'b1;
            wr_idx     <= {3'b000, head.rs1[2:0]};
            wr_val     <= {2'b00, head.rs2[2:0]};
            res_mux_fb <= head.rs1[3];
          end
          3'b101: begin
            io_use_we <= 1'b1;
            wr_val    <= head.rs1[4:0];
          end
          default: ;
        endcase
      end
    end
  end

  // Pending flags cover every occupied slot; the head stays in the FIFO
  // through its WRITE cycle, so the in-flight entry is included.
  always_comb begin
    entry_t e;
    cfg_pending = '0;
    for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
      e = mem[rd_ptr + AW'(i)];
      if ((AW+1)'(i) < count) begin
        if ((e.f3 == 3'b010) || (e.f3 == 3'b011)) begin
          cfg_pending = '1;
        end else if ((e.f3 == 3'b001) || (e.f3 == 3'b100) || (e.f3 == 3'b101)) begin
          for (int unsigned r = 0; r < NUM_RCAS; r++)
            if (e.f7 == 7'(r)) cfg_pending[r] = 1'b1;
        end
      end
    end
  end

`ifdef RCA_CFG_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_writes       <= '0;
      perf_stall_cycles <= '0;
    end else begin
      if (state == WRITE) perf_writes       <= perf_writes + 32'd1;
      if (state == STALL) perf_stall_cycles <= perf_stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rca_cfg_decoder.sv
// tb_rca_cfg_decoder
//   Scoreboard bench for rca_cfg_decoder: expected writes are queued at
//   accept time and compared when a write strobe appears.
module tb_rca_cfg_decoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        issue_valid = 1'b0;
  logic        issue_ready;
  logic [2:0]  funct3 = '0;
  logic [6:0]  funct7 = '0;
  logic [31:0] rs1_data = '0, rs2_data = '0;
  logic [3:0]  rca_busy = '0;
  logic [3:0]  cfg_pending;
  logic        illegal;
  logic [1:0]  wr_rca;
  logic [5:0]  wr_idx;
  logic [4:0]  wr_val;
  logic        cpu_reg_we, cpu_reg_is_dest, cpu_reg_is_fb;
  logic        grid_mux_we, io_mux_we, res_mux_we, res_mux_fb, io_use_we;
`ifdef RCA_CFG_PERF_EN
  logic [31:0] perf_writes, perf_stall_cycles;
`endif

  rca_cfg_decoder #(.NUM_RCAS(4), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .funct3(funct3), .funct7(funct7), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .rca_busy(rca_busy), .cfg_pending(cfg_pending), .illegal(illegal),
    .wr_rca(wr_rca), .wr_idx(wr_idx), .wr_val(wr_val),
    .cpu_reg_we(cpu_reg_we), .cpu_reg_is_dest(cpu_reg_is_dest), .cpu_reg_is_fb(cpu_reg_is_fb),
    .grid_mux_we(grid_mux_we), .io_mux_we(io_mux_we),
    .res_mux_we(res_mux_we), .res_mux_fb(res_mux_fb), .io_use_we(io_use_we)
`ifdef RCA_CFG_PERF_EN
    , .perf_writes(perf_writes), .perf_stall_cycles(perf_stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] we;   // {io_use, res_mux, io_mux, grid_mux, cpu_reg}
    logic [1:0] rca;
    logic [5:0] idx;
    logic [4:0] val;
    logic       dest, fb, rfb;
    int         due;  // cycle the strobe must appear in, -1 = unchecked
  } wr_t;

  wr_t sb[$];
  int  checks = 0, errors = 0;
  int  cyc = 0;
  int  accepted = 0;
  int  exp_illegal = 0, seen_illegal = 0;
  logic hold = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Independent reference decode; returns 0 for illegal instructions.
  function automatic logic model(input logic [2:0] f3, input logic [6:0] f7,
                                 input logic [31:0] r1, input logic [31:0] r2,
                                 output wr_t w);
    w = '{we: '0, rca: f7[1:0], idx: '0, val: '0, dest: 0, fb: 0, rfb: 0, due: -1};
    case (f3)
      3'b001: begin w.we = 5'b00001; w.idx = {3'd0, r1[2:0]}; w.val = r2[4:0];
                    w.dest = r1[3]; w.fb = r1[4]; return f7 < 7'd4; end
      3'b010: begin w.we = 5'b00010; w.idx = r1[5:0]; w.val = {2'd0, r2[2:0]}; return 1; end
      3'b011: begin w.we = 5'b00100; w.idx = r1[5:0]; w.val = {2'd0, r2[2:0]}; return 1; end
      3'b100: begin w.we = 5'b01000; w.idx = {3'd0, r1[2:0]}; w.val = {2'd0, r2[2:0]};
                    w.rfb = r1[3]; return f7 < 7'd4; end
      3'b101: begin w.we = 5'b10000; w.val = r1[4:0]; return f7 < 7'd4; end
      default: return 0;
    endcase
  endfunction

  // Monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    logic [4:0] wes;
    wr_t e;
    wes = {io_use_we, res_mux_we, io_mux_we, grid_mux_we, cpu_reg_we};
    if (rst_n) begin
      if (illegal) begin
        seen_illegal++;
        chk("illegal_no_we", 64'(wes), 64'd0);
      end
      if (wes != '0) begin
        if (hold) chk("early_strobe", 64'd1, 64'd0);
        if (sb.size() == 0) begin
          chk("spurious_strobe", 64'(wes), 64'd0);
        end else begin
          e = sb.pop_front();
          chk("we",   64'(wes),    64'(e.we));
          chk("rca",  64'(wr_rca), 64'(e.rca));
          chk("idx",  64'(wr_idx), 64'(e.idx));
          chk("val",  64'(wr_val), 64'(e.val));
          chk("flags", 64'({cpu_reg_is_dest, cpu_reg_is_fb, res_mux_fb}),
                       64'({e.dest, e.fb, e.rfb}));
          if (e.due >= 0) chk("strobe_cycle", 64'(cyc), 64'(e.due));
        end
      end
    end
  end

  task automatic issue(input logic [2:0] f3, input logic [6:0] f7,
                       input logic [31:0] r1, input logic [31:0] r2, input int lat);
    wr_t w;
    int n = 0;
    @(negedge clk);
    funct3 = f3; funct7 = f7; rs1_data = r1; rs2_data = r2; issue_valid = 1'b1;
    while (!issue_ready && n < 200) begin @(negedge clk); n++; end
    if (!issue_ready) begin
      chk("ready_timeout", 64'd0, 64'd1);
      issue_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    accepted++;
    if (model(f3, f7, r1, r2, w)) begin
      w.due = (lat < 0) ? -1 : (cyc - 1) + lat;
      sb.push_back(w);
    end else begin
      exp_illegal++;
    end
    issue_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 300) begin @(negedge clk); n++; end
    chk("drain", 64'(sb.size()), 64'd0);
    repeat (3) @(negedge clk);
  endtask

  task automatic release_busy();
    @(negedge clk);
    rca_busy = '0;
    hold = 1'b0;
    if (sb.size() != 0) sb[0].due = cyc + 1;
  endtask

  initial begin
    int n;
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_ready", 64'(issue_ready), 64'd0);
    chk("rst_pending", 64'(cfg_pending), 64'd0);
    chk("rst_outs", 64'({wr_rca, wr_idx, wr_val, illegal, cpu_reg_we, grid_mux_we,
                         io_mux_we, res_mux_we, io_use_we}), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", 64'(issue_ready), 64'd1);

    // Single write with minimum latency
    issue(3'b001, 7'd2, 32'h1B, 32'h0D, 3);
    @(negedge clk);
    chk("pending_single", 64'(cfg_pending), 64'b0100);
    drain();
    chk("pending_cleared", 64'(cfg_pending), 64'd0);

    // Per-RCA stall
    rca_busy = 4'b0001; hold = 1'b1;
    issue(3'b100, 7'd0, 32'h0F, 32'h6, -1);
    repeat (6) @(negedge clk);
    chk("pending_stall", 64'(cfg_pending), 64'b0001);
`ifdef RCA_CFG_PERF_EN
    begin
      logic [31:0] s0;
      s0 = perf_stall_cycles;
      @(negedge clk);
      chk("perf_stall_inc", 64'(perf_stall_cycles - s0), 64'd1);
    end
`endif
    release_busy();
    drain();

    // Global type blocked by any busy RCA
    rca_busy = 4'b1000; hold = 1'b1;
    issue(3'b010, 7'd1, 32'h2D, 32'h5, -1);
    repeat (5) @(negedge clk);
    chk("pending_global", 64'(cfg_pending), 64'b1111);
    release_busy();
    drain();

    // Full FIFO and ordering
    rca_busy = 4'b1111; hold = 1'b1; accepted = 0;
    fork
      begin
        issue(3'b001, 7'd0, 32'h05, 32'h11, -1);
        issue(3'b100, 7'd1, 32'h0A, 32'h03, -1);
        issue(3'b101, 7'd1, 32'h17, 32'h00, -1);
        issue(3'b001, 7'd0, 32'h12, 32'h1F, -1);
        issue(3'b011, 7'd3, 32'h3C, 32'h07, -1);
      end
      begin
        n = 0;
        do begin @(negedge clk); n++; end while (issue_ready && n < 100);
        chk("full_accepts", 64'(accepted), 64'd4);
        repeat (3) @(negedge clk);
        chk("full_ready_low", 64'(issue_ready), 64'd0);
        chk("pending_full", 64'(cfg_pending), 64'b0011);
        release_busy();
      end
    join
    drain();

    // Illegal instructions
    issue(3'b110, 7'd0, 32'h1, 32'h1, -1);
    issue(3'b001, 7'd5, 32'h1, 32'h1, -1);
    issue(3'b000, 7'd0, 32'h1, 32'h1, -1);
    repeat (12) @(negedge clk);

    // Random mix, no busy
    for (int k = 0; k < 24; k++)
      issue(3'($urandom_range(0, 7)), 7'($urandom_range(0, 5)), $urandom, $urandom, -1);
    drain();
    repeat (10) @(negedge clk);
    chk("illegal_count", 64'(seen_illegal), 64'(exp_illegal));

    // Reset while stalled
    rca_busy = 4'b1111; hold = 1'b1;
    issue(3'b011, 7'd0, 32'h21, 32'h2, -1);
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_ready", 64'(issue_ready), 64'd0);
    chk("rst_mid_pending", 64'(cfg_pending), 64'd0);
    chk("rst_mid_outs", 64'({wr_rca, wr_idx, wr_val, illegal, cpu_reg_we, grid_mux_we,
                             io_mux_we, res_mux_we, io_use_we}), 64'd0);
    sb.delete();
    hold = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    rca_busy = '0;
    @(negedge clk);
    chk("ready_after_rst2", 64'(issue_ready), 64'd1);
    repeat (8) @(negedge clk);
    chk("flushed_pending", 64'(cfg_pending), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rca_cfg_decoder.md
RCA_CFG_DECODER -- requirements
Module: rca_cfg_decoder

Interface
REQ-001 SHALL have parameters: NUM_RCAS, default 4, number of RCAs; FIFO_DEPTH, default 4, power of two, pending config instructions.
REQ-002 SHALL have ports: clk, in, 1, the only clock; rst_n, in, 1, asynchronous active-low reset.
REQ-003 SHALL have ports: issue_valid, in, 1; issue_ready, out, 1; funct3, in, 3; funct7, in, 7; rs1_data, in, 32; rs2_data, in, 32. The instruction is accepted when issue_valid and issue_ready are both high.
REQ-004 SHALL have ports: rca_busy, in, NUM_RCAS, RCA executing; cfg_pending, out, NUM_RCAS, config outstanding per RCA; illegal, out, 1, one-cycle pulse.
REQ-005 SHALL have ports: wr_rca, out, 2, target RCA; wr_idx, out, 6, MUX or port index; wr_val, out, 5, value written.
REQ-006 SHALL have ports: cpu_reg_we, out, 1; cpu_reg_is_dest, out, 1, from rs1[3]; cpu_reg_is_fb, out, 1, from rs1[4].
REQ-007 SHALL have ports: grid_mux_we, out, 1; io_mux_we, out, 1; res_mux_we, out, 1; res_mux_fb, out, 1, from rs1[3]; io_use_we, out, 1.

Function
REQ-008 SHALL buffer accepted instructions in an in-order FIFO of FIFO_DEPTH entries; issue_ready SHALL be the registered value of !full.
REQ-009 SHALL allow a push and a pop in the same cycle; the occupancy count is then unchanged.
REQ-010 SHALL use a state machine with states IDLE, DECODE, STALL and WRITE.
REQ-011 SHALL move IDLE->DECODE when the FIFO is non-empty.
REQ-012 In DECODE, SHALL go to WRITE if the head is legal and its target is free, to STALL if the target is busy, and drop an illegal head (pop, illegal=1, back to IDLE).
REQ-013 A target is busy when rca_busy[funct7] is high for per-RCA types, or when any rca_busy bit is high for global types (010, 011). STALL SHALL re-check every cycle and go to WRITE when the target is free.
REQ-014 In WRITE, SHALL assert exactly one write enable for one cycle, pop the head, and return to DECODE if the FIFO is non-empty, otherwise to IDLE.
REQ-015 SHALL map funct3 to write enables: 001 cpu_reg_we, 010 grid_mux_we, 011 io_mux_we, 100 res_mux_we, 101 io_use_we.
REQ-016 SHALL treat funct3 000, 110 and 111 as illegal, and funct7 >= NUM_RCAS as illegal for types 001, 100 and 101.
REQ-017 SHALL drive the write fields as follows:
- wr_rca = funct7[1:0].
- wr_idx: type 001 = rs1[2:0]; type 100 = rs1[2:0]; types 010 and 011 = rs1[5:0].
- wr_val: type 001 = rs2[4:0]; types 010, 011 and 100 = rs2[2:0], zero-extended; type 101 = rs1[4:0].
- All unused bits SHALL be 0.
REQ-018 All write-side outputs SHALL be registered and SHALL be 0 outside WRITE.
REQ-019 Minimum latency SHALL be 3 cycles: accept in cycle t, DECODE in t+2, write strobe in t+3.
REQ-020 cfg_pending[r] SHALL be high while any FIFO entry or the in-flight head targets RCA r; a global type sets all bits.
REQ-021 A stall SHALL never drop or reorder entries; younger entries wait behind the stalled head.

Reset
REQ-022 On rst_n low, SHALL go to IDLE immediately and flush the FIFO, including any write in flight.
REQ-023 During reset, SHALL drive issue_ready=0, all write enables and illegal to 0, cfg_pending to 0, and all data outputs to 0.
REQ-024 issue_ready SHALL rise on the first clk edge after rst_n deasserts.

Configuration
REQ-025 Macro RCA_CFG_PERF_EN.
- Defined: SHALL add outputs perf_writes (out, 32, count of write strobes) and perf_stall_cycles (out, 32, cycles spent in STALL). Both reset to 0 and wrap modulo 2^32.
- Undefined: these ports and counters SHALL not exist; all other behaviour is identical.

Verification
REQ-026 Single write: funct3=001, funct7=2, rs1=0x1B, rs2=0x0D, rca_busy=0 -> cpu_reg_we pulse 3 cycles after accept, with wr_rca=2, wr_idx=3, is_dest=1, is_fb=1, wr_val=13; cfg_pending=4'b0100 until the strobe.
REQ-027 Stall: rca_busy=4'b0001, funct3=100, funct7=0 -> no strobe; rca_busy drops at cycle 10 -> res_mux_we in cycle 11, perf_stall_cycles increments per stalled cycle.
REQ-028 Global block: funct3=010 with rca_busy=4'b1000 -> stalls, cfg_pending=4'b1111; when busy clears -> grid_mux_we with wr_idx=rs1[5:0].
REQ-029 Full/ordering: push 5 back-to-back with rca_busy=4'b1111 -> issue_ready low after 4 entries; when busy clears -> 4 strobes in issue order.
REQ-030 Illegal and reset: funct3=110 -> illegal pulse with no write enable; reset asserted during STALL -> outputs 0 at once, FIFO empty after release.
